// File: rtl/uart_rx_checker_if.sv
// Signal bundle between the UART channel selector/checker and its environment.
interface uart_rx_checker_if #(
  parameter int CNT_W = 16
);
  logic [255:0]     uart_bus;
  logic [7:0]       sel;
  logic             clr_cnt;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             frame_err;
  logic             mismatch;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;
  logic             busy;

  modport master (
    output uart_bus, sel, clr_cnt,
    input  rx_byte, rx_valid, frame_err, mismatch, good_cnt, bad_cnt, busy
  );

  modport slave (
    input  uart_bus, sel, clr_cnt,
    output rx_byte, rx_valid, frame_err, mismatch, good_cnt, bad_cnt, busy
  );
endinterface

// File: rtl/uart_rx_checker.sv
// Selects one UART line, decodes 8N1 frames by oversampling, checks the byte
// against the channel index and keeps saturating good/bad frame counters.
module uart_rx_checker #(
  parameter int CLKS_PER_BIT = 250,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  uart_rx_checker_if.slave bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t           state;
  logic             s1, rxs, rxs_d;
  logic [1:0]       flush;
  logic             armed;
  logic [7:0]       sel_q;
  logic [7:0]       shreg;
  logic [2:0]       idx;
  logic [BW-1:0]    bit_cnt;
  logic [7:0]       rx_byte;
  logic             rx_valid, frame_err, mismatch;
  logic [CNT_W-1:0] good_cnt, bad_cnt;
  logic             line;

  // Mid-frame the line stays pinned to the channel latched at start.
  assign line = bus.uart_bus[(state == IDLE) ? bus.sel : sel_q];

  // armed waits until the synchronizer holds a real high sample, so a line
  // that is already low when reset is released cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
      flush <= 2'd0;
      armed <= 1'b0;
    end else begin
      s1    <= line;
      rxs   <= s1;
      rxs_d <= rxs;
      if (flush != 2'd3) flush <= flush + 2'd1;
      if (flush == 2'd3 && rxs) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 8'd0;
      shreg     <= 8'd0;
      idx       <= 3'd0;
      bit_cnt   <= '0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      mismatch  <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && rxs_d && !rxs) begin
            sel_q   <= bus.sel;
            bit_cnt <= HALF;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          else if (!rxs) begin
            bit_cnt <= FULL;
            idx     <= 3'd0;
            state   <= DATA;
          end else state <= IDLE;
        end
        DATA: begin
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          else begin
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= FULL;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          else begin
            rx_byte   <= shreg;
            rx_valid  <= 1'b1;
            frame_err <= !rxs;
            mismatch  <= rxs && (shreg != sel_q);
            state     <= rxs ? IDLE : WAIT_HI;
          end
        end
        WAIT_HI: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr_cnt) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (rx_valid) begin
      if (frame_err || mismatch) begin
        if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
      end else if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
    end
  end

  assign bus.rx_byte   = rx_byte;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.mismatch  = mismatch;
  assign bus.good_cnt  = good_cnt;
  assign bus.bad_cnt   = bad_cnt;
  assign bus.busy      = (state != IDLE);
endmodule
